// File: rtl/wb_defs.sv
// Shared constants for the CPU-to-Wishbone master bridge: FSM encodings and
// readable names for the stall request and generic boolean values.
package wb_defs;

    localparam logic [1:0] WB_IDLE           = 2'd0;
    localparam logic [1:0] WB_BUSY           = 2'd1;
    localparam logic [1:0] WB_WAIT_FOR_STALL = 2'd2;
    localparam logic [1:0] WB_BACKOFF        = 2'd3;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;
    localparam logic TRUE    = 1'b1;
    localparam logic FALSE   = 1'b0;

endpackage

// File: rtl/wb_term_timer.sv
// Loadable down-counter shared by the response timeout and the retry back-off.
// It saturates at zero, and the zero flag is what the controller watches.
module wb_term_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/wishbone_master_if.sv
// Turns a CPU single access into a Wishbone B3 classic single cycle. It stalls the
// pipeline until completion and adds bounded retry, back-off and a response timeout.
module wishbone_master_if
    import wb_defs::*;
#(
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int STALL_W   = 6,
    parameter int TIMEOUT   = 256,
    parameter int MAX_RETRY = 3,
    parameter int BACKOFF   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STALL_W-1:0] stall_i,
    input  logic              flush_i,
    input  logic              cpu_ce_i,
    input  logic              cpu_we_i,
    input  logic [AW-1:0]     cpu_addr_i,
    input  logic [DW-1:0]     cpu_data_i,
    input  logic [DW/8-1:0]   cpu_sel_i,
    output logic [DW-1:0]     cpu_data_o,
    output logic              cpu_err_o,
    output logic              stallreq_o,
    input  logic [DW-1:0]     wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,
    input  logic              wb_rty_i,
    output logic [AW-1:0]     wb_adr_o,
    output logic [DW-1:0]     wb_dat_o,
    output logic              wb_we_o,
    output logic [DW/8-1:0]   wb_sel_o,
    output logic              wb_stb_o,
    output logic              wb_cyc_o,
    output logic [1:0]        dbg_state_o
);

    localparam int TMAX = (TIMEOUT > BACKOFF) ? TIMEOUT : BACKOFF;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int RW   = $clog2(MAX_RETRY + 1) + 1;
    localparam logic [TW-1:0] TIMEOUT_LOAD = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [TW-1:0] BACKOFF_LOAD = TW'(BACKOFF - 1);

    logic [1:0]    state;
    logic [RW-1:0] retry_cnt;
    logic [DW-1:0] rd_buf;
    logic          err_buf;
    logic          timer_load, timer_en, timer_zero;
    logic [TW-1:0] timer_val;

    // Termination decode, priority ACK > ERR > RTY > timeout; all gated by BUSY.
    logic in_busy, term_ack, term_err, rty_hit, retry_ok, tmo, fail, done, start;
    assign in_busy  = (state == WB_BUSY);
    assign term_ack = in_busy & wb_ack_i;
    assign term_err = in_busy & ~wb_ack_i & wb_err_i;
    assign rty_hit  = in_busy & ~wb_ack_i & ~wb_err_i & wb_rty_i;
    assign retry_ok = rty_hit & (retry_cnt < RW'(MAX_RETRY));
    assign tmo      = in_busy & ~wb_ack_i & ~wb_err_i & ~wb_rty_i & (TIMEOUT != 0) & timer_zero;
    assign fail     = term_err | (rty_hit & ~retry_ok) | tmo;
    assign done     = term_ack | fail;
    assign start    = (state == WB_IDLE) & cpu_ce_i & ~flush_i;

    assign dbg_state_o = state;

    wb_term_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .en       (timer_en),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

    always_comb begin
        timer_load = FALSE;
        timer_en   = FALSE;
        timer_val  = TIMEOUT_LOAD;
        case (state)
            WB_IDLE: timer_load = start;
            WB_BUSY: begin
                if (retry_ok) begin
                    timer_load = TRUE;
                    timer_val  = BACKOFF_LOAD;
                end else begin
                    timer_en = TRUE;
                end
            end
            WB_BACKOFF: begin
                if (timer_zero && !flush_i) timer_load = TRUE;
                else                        timer_en   = TRUE;
            end
            default: ;
        endcase
    end

    always_comb begin
        stallreq_o = NO_STOP;
        cpu_data_o = '0;
        cpu_err_o  = FALSE;
        if (!rst) begin
            case (state)
                WB_IDLE: stallreq_o = start ? STOP : NO_STOP;
                WB_BUSY: begin
                    stallreq_o = done ? NO_STOP : STOP;
                    if (term_ack && !wb_we_o) cpu_data_o = wb_dat_i;
                    cpu_err_o = fail;
                end
                WB_WAIT_FOR_STALL: begin
                    cpu_data_o = rd_buf;
                    cpu_err_o  = err_buf;
                end
                WB_BACKOFF: stallreq_o = STOP;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WB_IDLE;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            wb_we_o   <= FALSE;
            wb_sel_o  <= '0;
            wb_stb_o  <= FALSE;
            wb_cyc_o  <= FALSE;
            rd_buf    <= '0;
            err_buf   <= FALSE;
            retry_cnt <= '0;
        end else begin
            case (state)
                WB_IDLE: begin
                    if (start) begin
                        wb_adr_o  <= cpu_addr_i;
                        wb_dat_o  <= cpu_data_i;
                        wb_we_o   <= cpu_we_i;
                        wb_sel_o  <= cpu_sel_i;
                        wb_stb_o  <= TRUE;
                        wb_cyc_o  <= TRUE;
                        retry_cnt <= '0;
                        state     <= WB_BUSY;
                    end
                end
                WB_BUSY: begin
                    if (done) begin
                        wb_adr_o <= '0;
                        wb_dat_o <= '0;
                        wb_we_o  <= FALSE;
                        wb_sel_o <= '0;
                        wb_stb_o <= FALSE;
                        wb_cyc_o <= FALSE;
                        rd_buf   <= (term_ack && !wb_we_o) ? wb_dat_i : '0;
                        err_buf  <= fail;
                        state    <= (stall_i != '0) ? WB_WAIT_FOR_STALL : WB_IDLE;
                    end else if (retry_ok) begin
                        // Address/data/select stay put so the re-issue repeats the access.
                        wb_stb_o  <= FALSE;
                        wb_cyc_o  <= FALSE;
                        retry_cnt <= retry_cnt + 1'b1;
                        state     <= WB_BACKOFF;
                    end else if (flush_i) begin
                        wb_adr_o <= '0;
                        wb_dat_o <= '0;
                        wb_we_o  <= FALSE;
                        wb_sel_o <= '0;
                        wb_stb_o <= FALSE;
                        wb_cyc_o <= FALSE;
                        rd_buf   <= '0;
                        state    <= WB_IDLE;
                    end
                end
                WB_BACKOFF: begin
                    if (flush_i) begin
                        wb_adr_o <= '0;
                        wb_dat_o <= '0;
                        wb_we_o  <= FALSE;
                        wb_sel_o <= '0;
                        state    <= WB_IDLE;
                    end else if (timer_zero) begin
                        wb_stb_o <= TRUE;
                        wb_cyc_o <= TRUE;
                        state    <= WB_BUSY;
                    end
                end
                WB_WAIT_FOR_STALL: begin
                    if (flush_i) begin
                        err_buf <= FALSE;
                        state   <= WB_IDLE;
                    end else if (stall_i == '0) begin
                        state <= WB_IDLE;
                    end
                end
                default: state <= WB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wishbone_master_if.sv
// Directed bench for wishbone_master_if: a scripted Wishbone slave, a CPU-side driver
// that queues expected responses, and a monitor that checks each delivered response.
module tb_wishbone_master_if;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = 6;
    localparam int R_NONE = 0, R_ACK = 1, R_ERR = 2, R_RTY = 3, R_ERRACK = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [SW-1:0] stall_i;
    logic          flush_i, cpu_ce_i, cpu_we_i;
    logic [AW-1:0] cpu_addr_i;
    logic [DW-1:0] cpu_data_i;
    logic [3:0]    cpu_sel_i;
    logic [DW-1:0] cpu_data_o;
    logic          cpu_err_o, stallreq_o;
    logic [DW-1:0] wb_dat_i;
    logic          wb_ack_i, wb_err_i, wb_rty_i;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic          wb_we_o;
    logic [3:0]    wb_sel_o;
    logic          wb_stb_o, wb_cyc_o;
    logic [1:0]    dbg_state_o;

    wishbone_master_if #(
        .DW(DW), .AW(AW), .STALL_W(SW), .TIMEOUT(8), .MAX_RETRY(3), .BACKOFF(4)
    ) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_data_i(cpu_data_i), .cpu_sel_i(cpu_sel_i), .cpu_data_o(cpu_data_o),
        .cpu_err_o(cpu_err_o), .stallreq_o(stallreq_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
        .dbg_state_o(dbg_state_o)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];   // {err, data}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scripted slave: responds resp_seq[attempt] after slave_delay extra BUSY cycles
    int          resp_seq[8];
    int          slave_delay = 0;
    int          attempt = 0;
    int          busy_cnt = 0;
    int          gap_cnt = 0;
    logic        prev_cyc = 1'b0;
    logic [31:0] slave_rdata = '0;
    logic [31:0] adr_log[8];
    logic [31:0] dat_log[8];
    logic        we_log[8];
    logic [3:0]  sel_log[8];
    int          gap_log[8];

    initial begin
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_dat_i = '0;
        for (int i = 0; i < 8; i++) resp_seq[i] = R_NONE;
        forever begin
            @(posedge clk); #1;
            wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
            wb_dat_i = 32'hA5A5_A5A5;
            if (wb_cyc_o && wb_stb_o) begin
                if (!prev_cyc && attempt < 8) begin
                    adr_log[attempt] = wb_adr_o;
                    dat_log[attempt] = wb_dat_o;
                    we_log[attempt]  = wb_we_o;
                    sel_log[attempt] = wb_sel_o;
                    gap_log[attempt] = gap_cnt;
                    gap_cnt = 0;
                end
                busy_cnt++;
                if (busy_cnt == slave_delay + 1 && attempt < 8) begin
                    case (resp_seq[attempt])
                        R_ACK:    begin wb_ack_i = 1'b1; wb_dat_i = slave_rdata; end
                        R_ERR:    wb_err_i = 1'b1;
                        R_RTY:    wb_rty_i = 1'b1;
                        R_ERRACK: begin wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = slave_rdata; end
                        default: ;
                    endcase
                    attempt++;
                end
                prev_cyc = 1'b1;
            end else begin
                busy_cnt = 0;
                gap_cnt++;
                prev_cyc = 1'b0;
            end
        end
    end

    // Monitor: a response is delivered when the CPU requests and the bridge stops stalling
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (!rst && cpu_ce_i && !stallreq_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got %0h expected none", {cpu_err_o, cpu_data_o});
                end else begin
                    e = exp_q.pop_front();
                    check("resp", 64'({cpu_err_o, cpu_data_o}), 64'(e));
                end
            end
        end
    end

    // Driver tasks
    task automatic slave_cfg(input int delay, input int s0, input int s1, input int s2,
                             input int s3, input logic [31:0] rdata);
        slave_delay = delay;
        for (int i = 0; i < 8; i++) resp_seq[i] = R_NONE;
        resp_seq[0] = s0; resp_seq[1] = s1; resp_seq[2] = s2; resp_seq[3] = s3;
        slave_rdata = rdata;
        attempt = 0;
    endtask

    task automatic do_access(input string name, input logic we, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] sel,
                             input logic [31:0] exp_data, input logic exp_err,
                             output int stall_cycles);
        logic got;
        exp_q.push_back({exp_err, exp_data});
        cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_data_i = data; cpu_sel_i = sel;
        stall_cycles = 0;
        got = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            if (stallreq_o) stall_cycles++;
            else            got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_no_response: got none expected response within 64 cycles", name);
        end
        @(posedge clk); #1;
        cpu_ce_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0; cpu_sel_i = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        rst = 1'b1; stall_i = '0; flush_i = 1'b0; cpu_ce_i = 1'b1; cpu_we_i = 1'b0;
        cpu_addr_i = 32'h40; cpu_data_i = '0; cpu_sel_i = 4'hF;

        // Reset state; request held during reset must not raise a stall
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stallreq", 64'(stallreq_o), 64'(0));
        check("rst_cyc", 64'({wb_cyc_o, wb_stb_o, wb_we_o}), 64'(0));
        check("rst_adr", 64'(wb_adr_o), 64'(0));
        check("rst_state", 64'(dbg_state_o), 64'(0));
        cpu_ce_i = 1'b0; cpu_addr_i = '0; cpu_sel_i = '0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Read, ACK two cycles after strobe
        @(negedge clk); slave_cfg(2, R_ACK, R_NONE, R_NONE, R_NONE, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        do_access("read", 1'b0, 32'h100, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, sc);
        check("read_stall_cycles", 64'(sc), 64'(3));
        check("read_cyc_after", 64'(wb_cyc_o), 64'(0));
        check("read_adr", 64'(adr_log[0]), 64'(32'h100));
        check("read_sel_we", 64'({sel_log[0], we_log[0]}), 64'({4'hF, 1'b0}));

        // Write completing while another stage holds the pipeline
        @(negedge clk); slave_cfg(1, R_ACK, R_NONE, R_NONE, R_NONE, 32'h0);
        stall_i = 6'b000011;
        @(posedge clk); #1;
        do_access("write", 1'b1, 32'h200, 32'h1234_5678, 4'hF, 32'h0, 1'b0, sc);
        check("write_bus", 64'({we_log[0], adr_log[0], dat_log[0]}), 64'({1'b1, 32'h200, 32'h1234_5678}));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wait_state", 64'(dbg_state_o), 64'(2));
            check("wait_out", 64'({stallreq_o, cpu_err_o, cpu_data_o}), 64'(0));
        end
        @(posedge clk); #1; stall_i = '0;
        @(posedge clk); #1;
        check("wait_release", 64'(dbg_state_o), 64'(0));

        // Two RTYs then ACK: four idle cycles between attempts, same address
        @(negedge clk); slave_cfg(0, R_RTY, R_RTY, R_ACK, R_NONE, 32'hCAFE_F00D);
        @(posedge clk); #1;
        do_access("retry", 1'b0, 32'h300, 32'h0, 4'h3, 32'hCAFE_F00D, 1'b0, sc);
        check("retry_attempts", 64'(attempt), 64'(3));
        check("retry_stall_cycles", 64'(sc), 64'(11));
        check("retry_gap1", 64'(gap_log[1]), 64'(4));
        check("retry_gap2", 64'(gap_log[2]), 64'(4));
        check("retry_adr", 64'({adr_log[1], adr_log[2]}), 64'({32'h300, 32'h300}));

        // Four RTYs exhaust the retry budget
        @(negedge clk); slave_cfg(0, R_RTY, R_RTY, R_RTY, R_RTY, 32'h1111_1111);
        @(posedge clk); #1;
        do_access("rty_exhaust", 1'b0, 32'h400, 32'h0, 4'hF, 32'h0, 1'b1, sc);
        check("exhaust_attempts", 64'(attempt), 64'(4));
        check("exhaust_stall_cycles", 64'(sc), 64'(16));

        // ERR and ACK together: ACK wins
        @(negedge clk); slave_cfg(1, R_ERRACK, R_NONE, R_NONE, R_NONE, 32'h0BAD_F00D);
        @(posedge clk); #1;
        do_access("err_ack", 1'b0, 32'h500, 32'h0, 4'hF, 32'h0BAD_F00D, 1'b0, sc);

        // Plain ERR under stall: error stays visible in WAIT, flush leaves
        @(negedge clk); slave_cfg(0, R_ERR, R_NONE, R_NONE, R_NONE, 32'h2222_2222);
        stall_i = 6'b000001;
        @(posedge clk); #1;
        do_access("err", 1'b0, 32'h600, 32'h0, 4'hF, 32'h0, 1'b1, sc);
        @(negedge clk);
        check("err_wait_hold", 64'({dbg_state_o, cpu_err_o, cpu_data_o}), 64'({2'd2, 1'b1, 32'h0}));
        flush_i = 1'b1;
        @(posedge clk); #1; flush_i = 1'b0; stall_i = '0;
        check("err_wait_flush", 64'(dbg_state_o), 64'(0));

        // Silent slave: error on the 8th BUSY cycle
        @(negedge clk); slave_cfg(0, R_NONE, R_NONE, R_NONE, R_NONE, 32'h0);
        @(posedge clk); #1;
        do_access("timeout", 1'b0, 32'h700, 32'h0, 4'hF, 32'h0, 1'b1, sc);
        check("timeout_stall_cycles", 64'(sc), 64'(8));
        check("timeout_after", 64'({wb_cyc_o, dbg_state_o}), 64'(0));

        // Flush in BUSY cycle 2: cycle dropped, no response
        @(negedge clk); slave_cfg(0, R_NONE, R_NONE, R_NONE, R_NONE, 32'h0);
        @(posedge clk); #1;
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h800; cpu_sel_i = 4'hF;
        @(posedge clk); #1; cpu_ce_i = 1'b0;
        @(posedge clk); #1; flush_i = 1'b1;
        @(negedge clk);
        check("flush_stallreq", 64'({stallreq_o, cpu_data_o}), 64'({1'b1, 32'h0}));
        @(posedge clk); #1; flush_i = 1'b0;
        check("flush_after", 64'({wb_cyc_o, wb_stb_o, wb_adr_o, dbg_state_o}), 64'(0));

        // Reset in the middle of back-off, then a clean request
        @(negedge clk); slave_cfg(0, R_RTY, R_ACK, R_NONE, R_NONE, 32'h0);
        @(posedge clk); #1;
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h900; cpu_sel_i = 4'h1;
        @(posedge clk); #1; cpu_ce_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("backoff_pre", 64'({dbg_state_o, wb_cyc_o, wb_adr_o}), 64'({2'd3, 1'b0, 32'h900}));
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_backoff", 64'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o}), 64'(0));
        check("rst_mid_state", 64'(dbg_state_o), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        slave_cfg(0, R_RTY, R_RTY, R_RTY, R_ACK, 32'h1357_9BDF);
        @(posedge clk); #1;
        do_access("post_rst", 1'b0, 32'hA00, 32'h0, 4'hF, 32'h1357_9BDF, 1'b0, sc);
        check("post_rst_attempts", 64'(attempt), 64'(4));
        check("post_rst_stall_cycles", 64'(sc), 64'(16));

        repeat (3) @(posedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wishbone_master_if.md
Name: wishbone_master_if

Overview:
- Parametrised successor to the single-port CPU-to-Wishbone bridge: one per CPU port (instruction and data), between the CPU pipeline and the Wishbone interconnect.
- Converts a CPU single-access request into a classic Wishbone B3 single read/write cycle and holds the pipeline until the cycle completes.
- Adds configurable data/address widths, ERR and RTY termination, bounded retry with back-off, a response timeout, and a bus-error indication to the CPU.
- Keeps read data/error valid while the pipeline is still stalled by another stage.

Parameters:
- DW, 32: data width in bits; multiple of 8.
- AW, 32: address width in bits.
- STALL_W, 6: width of the pipeline stall vector.
- TIMEOUT, 256: BUSY cycles without ACK/ERR/RTY before forced error; 0 disables the timeout.
- MAX_RETRY, 3: RTY terminations tolerated per access; the next RTY becomes an error.
- BACKOFF, 4: idle cycles (CYC low) between an RTY and the re-issue; minimum 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- stall_i  in  STALL_W  pipeline stall vector from CTRL.
- flush_i  in  1  pipeline flush.
- cpu_ce_i  in  1  access request.
- cpu_we_i  in  1  1 = write.
- cpu_addr_i  in  AW  address.
- cpu_data_i  in  DW  write data.
- cpu_sel_i  in  DW/8  byte selects.
- cpu_data_o  out  DW  read data.
- cpu_err_o  out  1  access terminated with bus error.
- stallreq_o  out  1  pipeline stall request.
- wb_dat_i  in  DW  bus read data.
- wb_ack_i  in  1  normal termination.
- wb_err_i  in  1  error termination.
- wb_rty_i  in  1  retry termination.
- wb_adr_o  out  AW  registered address.
- wb_dat_o  out  DW  registered write data.
- wb_we_o  out  1  registered write enable.
- wb_sel_o  out  DW/8  registered byte selects.
- wb_stb_o  out  1  registered strobe.
- wb_cyc_o  out  1  registered cycle.

Behaviour:
- Reset: synchronous, active-high, on clk; reset takes effect on the next edge even mid-cycle. After reset:
  - all wb_* outputs = 0; state = IDLE;
  - rd_buf = 0, err_buf = 0, retry count = 0, timeout count = 0;
  - combinational outputs (cpu_data_o, cpu_err_o, stallreq_o) = 0 while rst = 1.
- Bus outputs are registered. cpu_data_o, cpu_err_o and stallreq_o are combinational from state and bus inputs.
- IDLE:
  - cpu_ce_i = 1 and flush_i = 0: stallreq_o = 1 this cycle. Next edge: latch addr/data/we/sel into wb_* outputs, stb = cyc = 1, retry count = 0, timeout count = 0, go to BUSY.
  - Otherwise: outputs 0.
- BUSY (cyc = stb = 1). Termination priority, highest first: ACK > ERR > RTY > timeout > flush.
  - ACK:
    - stallreq_o = 0 this cycle; cpu_data_o = wb_dat_i if latched we = 0, else 0.
    - Next edge: clear all wb_* outputs; rd_buf = wb_dat_i for reads, 0 for writes; err_buf = 0.
    - Next state: WAIT_STALL if stall_i != 0, else IDLE.
  - ERR: as ACK, but cpu_data_o = 0, cpu_err_o = 1 this cycle, rd_buf = 0, err_buf = 1.
  - RTY with retry count < MAX_RETRY:
    - stallreq_o stays 1.
    - Next edge: stb = cyc = 0, keep adr/dat/we/sel, retry count + 1, go to BACKOFF.
  - RTY with retry count = MAX_RETRY: handled as ERR.
  - Timeout: TIMEOUT != 0 and timeout count = TIMEOUT-1 with no termination → handled as ERR. Otherwise timeout count increments each BUSY cycle.
  - flush_i = 1 with no termination: clear all wb_* outputs, rd_buf = 0, go to IDLE; stallreq_o = 1 that cycle.
  - No event: stallreq_o = 1, cpu_data_o = 0.
- BACKOFF:
  - stallreq_o = 1. A down-counter loaded with BACKOFF-1 decrements each cycle.
  - At 0: stb = cyc = 1, timeout count = 0, go to BUSY.
  - flush_i = 1: clear all wb_* outputs, go to IDLE (retry abandoned).
- WAIT_STALL:
  - stallreq_o = 0, cpu_data_o = rd_buf, cpu_err_o = err_buf.
  - stall_i = 0: go to IDLE next edge.
  - flush_i = 1: go to IDLE, clear err_buf.
- Protocol rules:
  - A new cycle is never issued in the edge that ends one: at least 1 cycle with cyc = 0 between cycles.
  - wb_* inputs are ignored outside BUSY.
  - ACK/ERR/RTY asserted together resolve by the priority above.

Decomposition:
- Shared package wb_defs:
  - state encodings WB_IDLE = 0, WB_BUSY = 1, WB_WAIT_FOR_STALL = 2, WB_BACKOFF = 3 (2-bit);
  - Stop/NoStop and True/False constants.
- Sub-module wb_term_timer (shared timeout/back-off counter with load, enable, and zero flag), instantiated once; width = clog2(max(TIMEOUT, BACKOFF)+1).

Test Plan:
- Read: ce = 1, addr = 0x100, sel = 0xF; slave ACKs 2 cycles after stb with dat = 0xDEADBEEF, stall_i = 0 → stallreq_o high 3 cycles, cpu_data_o = 0xDEADBEEF in the ACK cycle, cyc low next edge.
- Write then held stall: write 0x12345678 to 0x200, ACK while stall_i = 6'b000011 for 3 cycles → WAIT_STALL; cpu_data_o = 0, stallreq_o = 0; back to IDLE after stall_i = 0.
- Retry: slave RTYs twice then ACKs; BACKOFF = 4 → cyc low exactly 4 cycles between attempts, same adr each time, final read data delivered, cpu_err_o = 0.
- Retry exhaustion and ERR: slave RTYs 4 times with MAX_RETRY = 3 → cpu_err_o = 1 on the 4th RTY. Separately, slave asserts ERR+ACK together → ACK wins, cpu_err_o = 0.
- Timeout: TIMEOUT = 8, slave never responds → cpu_err_o = 1 on the 8th BUSY cycle, cyc low next edge, state IDLE.
- Flush/reset: flush_i in BUSY cycle 2 → cyc = 0 next edge, no data. rst mid-BACKOFF → all wb_* = 0 next edge; next request issues cleanly with retry count = 0.
